code_sequencer: RTL and testbench

//  Drives the digit-entry interface of the combination lock: plays back a stored code
//  one digit at a time on number[3:0], with one active-low insere strobe per digit.

---
 rtl/lock_pkg.sv | 35 +++
 rtl/seg7_decoder.sv | 20 ++
 rtl/code_sequencer.sv | 174 +++++++++++++++++
 tb/tb_code_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock slice: sequencer state encoding,
// 7-segment constants and the digit-to-segment decoder used by the sequencer and the lock FSM.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } seq_state_e;

  // Segments are active-low, ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_D     = 7'b0100001;

  function automatic logic [6:0] seg7_digit(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational display decode for the sequencer: blank in IDLE, 'd' in DONE,
// otherwise the digit being sent (non-BCD nibbles show blank).
module seg7_decoder
  import lock_pkg::*;
(
  input  seq_state_e state,
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg7_digit(digit);
    if (state == IDLE) begin
      seg = SEG_BLANK;
    end else if (state == DONE) begin
      seg = SEG_D;
    end
  end

endmodule

// File: rtl/code_sequencer.sv
// Plays a stored BCD code into the lock's digit-entry port, one active-low insere strobe per digit.
// Optional macro CODE_FAULT_INJECT_EN: corrupt one chosen digit to (digit+1) mod 10.
module code_sequencer
  import lock_pkg::*;
#(
  parameter int                      NUM_DIGITS   = 6,
  parameter logic [4*NUM_DIGITS-1:0] CODE         = 24'h461575,
  parameter int                      SETUP_CYCLES = 2,
  parameter int                      GAP_CYCLES   = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       err_en,
  input  logic [2:0] err_idx,
  output logic [3:0] number,
  output logic       insere,
  output logic       busy,
  output logic       done,
  output logic [2:0] digit_idx,
  output logic [6:0] display_num
);

  localparam int CNT_MAX = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       number_q, number_d;
  logic             insere_q, insere_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [6:0]       display_q, display_d;
  logic             load_digit, clear_number, advance;
  logic [3:0]       sent_digit;
  logic [3:0]       code_digits [8];

  // Unused slots (index >= NUM_DIGITS) are unreachable; tie them off.
  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    if (gi < NUM_DIGITS) begin : g_used
      assign code_digits[gi] = CODE[4*gi +: 4];
    end else begin : g_pad
      assign code_digits[gi] = 4'd0;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    load_digit   = 1'b0;
    clear_number = 1'b0;
    advance      = 1'b0;
    if (abort) begin
      state_d      = IDLE;
      idx_d        = 3'd0;
      clear_number = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d    = SETUP;
            cnt_d      = SETUP_LOAD;
            idx_d      = 3'd0;
            load_digit = 1'b1;
          end
        end
        SETUP: begin
          if (cnt_q == '0) state_d = STROBE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        STROBE: begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            advance = 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == '0) advance = 1'b1;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
      if (advance) begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d    = SETUP;
          cnt_d      = SETUP_LOAD;
          idx_d      = idx_q + 3'd1;
          load_digit = 1'b1;
        end
      end
    end
  end

`ifdef CODE_FAULT_INJECT_EN
  logic       start_seq;
  logic       err_en_q, err_en_d;
  logic [2:0] err_idx_q, err_idx_d;
  logic [4:0] bumped;

  // Fault request is latched only when a sequence is actually launched.
  assign start_seq = !abort && start && (state_q == IDLE || state_q == DONE);
  assign err_en_d  = start_seq ? err_en  : err_en_q;
  assign err_idx_d = start_seq ? err_idx : err_idx_q;
  assign bumped    = {1'b0, code_digits[idx_d]} + 5'd1;
  assign sent_digit = (err_en_d && (err_idx_d == idx_d))
                    ? ((bumped >= 5'd10) ? 4'(bumped - 5'd10) : bumped[3:0])
                    : code_digits[idx_d];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_en_q  <= 1'b0;
      err_idx_q <= 3'd0;
    end else begin
      err_en_q  <= err_en_d;
      err_idx_q <= err_idx_d;
    end
  end
`else
  logic unused_fault;
  assign unused_fault = ^{err_en, err_idx};
  assign sent_digit   = code_digits[idx_d];
`endif

  assign number_d = clear_number ? 4'd0 : (load_digit ? sent_digit : number_q);
  assign insere_d = (state_d != STROBE);
  assign busy_d   = (state_d == SETUP) || (state_d == STROBE) || (state_d == GAP);
  assign done_d   = (state_d == DONE);

  seg7_decoder u_seg7 (
    .state (state_d),
    .digit (number_d),
    .seg   (display_d)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      number_q  <= 4'd0;
      insere_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      display_q <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      number_q  <= number_d;
      insere_q  <= insere_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      display_q <= display_d;
    end
  end

  assign number      = number_q;
  assign insere      = insere_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign digit_idx   = idx_q;
  assign display_num = display_q;

endmodule

// File: tb/tb_code_sequencer.sv
// Self-checking bench for code_sequencer (default parameters, fault injection disabled):
// table-driven vectors, hand-written corner sequences and random start/abort against a timeline model.
module tb_code_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       err_en = 1'b0;
  logic [2:0] err_idx = 3'd0;
  logic [3:0] number;
  logic       insere, busy, done;
  logic [2:0] digit_idx;
  logic [6:0] display_num;

  code_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .err_en      (err_en),
    .err_idx     (err_idx),
    .number      (number),
    .insere      (insere),
    .busy        (busy),
    .done        (done),
    .digit_idx   (digit_idx),
    .display_num (display_num)
  );

  always #5 clock = ~clock;

  localparam int PERIOD = 6;
  localparam int NDIG   = 6;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] SEGD  = 7'b0100001;

  int         code_dig [NDIG] = '{5, 7, 5, 1, 6, 4};
  logic [6:0] seg_tab  [10]   = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  // Timeline model: mode 0 idle, 1 running (t = cycles since launch), 2 done.
  int m_mode = 0;
  int m_t = 0;

  logic [16:0] outs;
  assign outs = {number, insere, busy, done, digit_idx, display_num};

  function automatic logic [16:0] pk(input int num, input bit ins, input bit bsy, input bit dn,
                                     input int idx, input logic [6:0] seg);
    return {4'(num), ins, bsy, dn, 3'(idx), seg};
  endfunction

  function automatic logic [16:0] model_exp();
    int d;
    if (m_mode == 0) return pk(0, 1'b1, 1'b0, 1'b0, 0, BLANK);
    if (m_mode == 2) return pk(code_dig[NDIG-1], 1'b1, 1'b0, 1'b1, NDIG-1, SEGD);
    d = code_dig[m_t / PERIOD];
    return pk(d, (m_t % PERIOD) != 2, 1'b1, 1'b0, m_t / PERIOD, seg_tab[d]);
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic s, input logic a);
    start   = s;
    abort   = a;
    err_en  = 1'($urandom_range(0, 1));
    err_idx = 3'($urandom_range(0, 7));
    @(posedge clock);
    if (a) begin
      m_mode = 0;
    end else if (m_mode != 1 && s) begin
      m_mode = 1;
      m_t    = 0;
    end else if (m_mode == 1) begin
      m_t++;
      if (m_t == NDIG * PERIOD) m_mode = 2;
    end
    @(negedge clock);
    if (!insere) strobe_cnt++;
    check("model", outs, model_exp());
  endtask

  typedef struct {
    string       name;
    logic        start;
    logic        abort;
    int          cycles;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{"idle",         1'b0, 1'b0, 1,  pk(0, 1, 0, 0, 0, BLANK)};
    vecs[1]  = '{"setup_d0",     1'b1, 1'b0, 1,  pk(5, 1, 1, 0, 0, seg_tab[5])};
    vecs[2]  = '{"strobe_d0",    1'b0, 1'b0, 2,  pk(5, 0, 1, 0, 0, seg_tab[5])};
    vecs[3]  = '{"gap_d0",       1'b0, 1'b0, 1,  pk(5, 1, 1, 0, 0, seg_tab[5])};
    vecs[4]  = '{"setup_d1",     1'b0, 1'b0, 3,  pk(7, 1, 1, 0, 1, seg_tab[7])};
    vecs[5]  = '{"strobe_d1",    1'b0, 1'b0, 2,  pk(7, 0, 1, 0, 1, seg_tab[7])};
    vecs[6]  = '{"done_edge36",  1'b0, 1'b0, 28, pk(4, 1, 0, 1, 5, SEGD)};
    vecs[7]  = '{"done_hold",    1'b0, 1'b0, 5,  pk(4, 1, 0, 1, 5, SEGD)};
    vecs[8]  = '{"restart",      1'b1, 1'b0, 1,  pk(5, 1, 1, 0, 0, seg_tab[5])};
    vecs[9]  = '{"no_retrigger", 1'b1, 1'b0, 5,  pk(5, 1, 1, 0, 0, seg_tab[5])};
    vecs[10] = '{"last_setup",   1'b0, 1'b0, 26, pk(4, 1, 1, 0, 5, seg_tab[4])};
    vecs[11] = '{"last_strobe",  1'b0, 1'b0, 1,  pk(4, 0, 1, 0, 5, seg_tab[4])};
    vecs[12] = '{"abort_wins",   1'b1, 1'b1, 1,  pk(0, 1, 0, 0, 0, BLANK)};
    vecs[13] = '{"abort_idle",   1'b0, 1'b1, 3,  pk(0, 1, 0, 0, 0, BLANK)};

    // Reset values.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_values", outs, pk(0, 1, 0, 0, 0, BLANK));
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      for (int c = 0; c < vecs[i].cycles; c++) cycle(vecs[i].start, vecs[i].abort);
      check(vecs[i].name, outs, vecs[i].exp);
      $display("vec %0d %s: outs=%h exp=%h", i, vecs[i].name, outs, vecs[i].exp);
    end

    // Abort during the third digit's SETUP: exactly two strobes reach the lock.
    cycle(1'b0, 1'b0);
    strobe_cnt = 0;
    cycle(1'b1, 1'b0);
    for (int c = 0; c < 2 * PERIOD; c++) cycle(1'b0, 1'b0);
    check("third_setup_idx", 17'(digit_idx), 17'd2);
    cycle(1'b0, 1'b1);
    check("abort_outs", outs, pk(0, 1, 0, 0, 0, BLANK));
    check("abort_strobes", 17'(strobe_cnt), 17'd2);
    $display("abort in digit 2 setup: strobes=%0d", strobe_cnt);

    // start held throughout: no mid-sequence restart, DONE lasts one cycle then replays digit 0.
    strobe_cnt = 0;
    for (int i = 0; i < 38; i++) begin
      cycle(1'b1, 1'b0);
      if (i == 6)  check("held_no_restart", 17'(number), 17'd7);
      if (i == 36) check("held_done", 17'(done), 17'd1);
      if (i == 37) check("held_replay", {12'd0, number, busy}, {12'd0, 4'd5, 1'b1});
    end
    check("held_strobes", 17'(strobe_cnt), 17'd6);
    $display("start held: strobes=%0d", strobe_cnt);
    cycle(1'b0, 1'b1);

    // Asynchronous reset inside a STROBE cycle.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("pre_reset_strobe", 17'(insere), 17'd0);
    reset_n = 1'b0;
    #1;
    check("async_reset_outs", outs, pk(0, 1, 0, 0, 0, BLANK));
    $display("reset in strobe: insere=%b display=%b", insere, display_num);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    m_mode = 0;
    m_t    = 0;

    // Random start/abort traffic against the timeline model.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 49) == 0));
    end
    $display("random phase: %0d cycles", 1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
